// File: rtl/fetch_unit_if.sv
// Fetch-stage handshake bundle: core control, PC redirect, instruction memory and decode-facing results.
interface fetch_unit_if;
    logic        enabled;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        completed;
    logic [31:0] pc_out;
    logic [31:0] instr_raw;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        busy;

    // Core control / memory model side
    modport master (
        output enabled, redirect_valid, redirect_pc, mem_ack, mem_rdata,
        input  mem_req, mem_addr, completed, pc_out, instr_raw, fault, fault_cause, busy
    );

    // Fetch unit side
    modport slave (
        input  enabled, redirect_valid, redirect_pc, mem_ack, mem_rdata,
        output mem_req, mem_addr, completed, pc_out, instr_raw, fault, fault_cause, busy
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory read per enabled pulse, reports faults.
// Optional memory-timeout fault is built when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rstn,
    fetch_unit_if.slave  fif
);
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        redir_pend;
    logic [31:0] redir_pc_q;
    logic [31:0] fetch_addr;

    // A zero-cycle timeout would fault every fetch before memory could answer.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be non-zero");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'b10;
    localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    // A same-cycle redirect overrides the stored PC for the fetch it accompanies.
    assign fetch_addr = fif.redirect_valid ? fif.redirect_pc : pc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            redir_pend      <= 1'b0;
            redir_pc_q      <= '0;
            fif.mem_req     <= 1'b0;
            fif.mem_addr    <= '0;
            fif.completed   <= 1'b0;
            fif.pc_out      <= '0;
            fif.instr_raw   <= '0;
            fif.fault       <= 1'b0;
            fif.fault_cause <= CAUSE_NONE;
            fif.busy        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            fif.completed <= 1'b0;
            case (state)
                IDLE: begin
                    if (fif.redirect_valid) pc <= fif.redirect_pc;
                    if (fif.enabled) begin
                        fif.busy <= 1'b1;
                        if (fetch_addr[1:0] != 2'b00) begin
                            fif.completed   <= 1'b1;
                            fif.fault       <= 1'b1;
                            fif.fault_cause <= CAUSE_MISALIGN;
                            fif.instr_raw   <= NOP_INSTR;
                            fif.pc_out      <= fetch_addr;
                            state           <= DONE;
                        end else begin
                            fif.mem_req  <= 1'b1;
                            fif.mem_addr <= fetch_addr;
                            state        <= REQ;
`ifdef FETCH_TIMEOUT_EN
                            to_cnt       <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    // Redirects during a fetch are deferred; the latest one wins.
                    if (fif.redirect_valid) begin
                        redir_pend <= 1'b1;
                        redir_pc_q <= fif.redirect_pc;
                    end
                    if (fif.mem_ack) begin
                        fif.mem_req     <= 1'b0;
                        fif.completed   <= 1'b1;
                        fif.instr_raw   <= fif.mem_rdata;
                        fif.pc_out      <= fif.mem_addr;
                        fif.fault       <= 1'b0;
                        fif.fault_cause <= CAUSE_NONE;
                        state           <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        fif.mem_req     <= 1'b0;
                        fif.completed   <= 1'b1;
                        fif.instr_raw   <= NOP_INSTR;
                        fif.pc_out      <= fif.mem_addr;
                        fif.fault       <= 1'b1;
                        fif.fault_cause <= CAUSE_TIMEOUT;
                        state           <= DONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    state      <= IDLE;
                    fif.busy   <= 1'b0;
                    redir_pend <= 1'b0;
                    // Faulted fetches keep the PC so a retry hits the same address.
                    if (fif.redirect_valid)  pc <= fif.redirect_pc;
                    else if (redir_pend)     pc <= redir_pc_q;
                    else if (!fif.fault)     pc <= fif.pc_out + 32'd4;
                end
                default: begin
                    state    <= IDLE;
                    fif.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetches against a PC model.
module tb_fetch_unit;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] m_pc;

    fetch_unit_if fif();

    fetch_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .fif  (fif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete fetch; the model PC advances from the architectural rules.
    task automatic fetch(input logic idle_redir, input logic [31:0] idle_pc, input int delay,
                         input int req_redir_at, input logic [31:0] req_pc,
                         input logic [31:0] data, input logic noisy_en);
        logic [31:0] a;
        logic        pend;
        logic [31:0] pend_pc;
        pend    = 1'b0;
        pend_pc = '0;
        fif.enabled        = 1'b1;
        fif.redirect_valid = idle_redir;
        fif.redirect_pc    = idle_pc;
        tick;
        fif.enabled        = 1'b0;
        fif.redirect_valid = 1'b0;
        if (idle_redir) m_pc = idle_pc;
        a = m_pc;
        check("busy_start", 32'(fif.busy), 32'd1);
        if (a[1:0] != 2'b00) begin
            check("mis_completed", 32'(fif.completed), 32'd1);
            check("mis_mem_req", 32'(fif.mem_req), 32'd0);
            check("mis_fault", 32'(fif.fault), 32'd1);
            check("mis_cause", 32'(fif.fault_cause), 32'd1);
            check("mis_instr", fif.instr_raw, NOP);
            check("mis_pc_out", fif.pc_out, a);
            tick;
            check("mis_completed_drop", 32'(fif.completed), 32'd0);
            check("mis_busy_drop", 32'(fif.busy), 32'd0);
            return;
        end
        check("req_mem_req", 32'(fif.mem_req), 32'd1);
        check("req_mem_addr", fif.mem_addr, a);
        check("req_completed", 32'(fif.completed), 32'd0);
        for (int i = 0; i <= delay; i++) begin
            fif.enabled        = noisy_en ? 1'($urandom_range(0, 1)) : 1'b0;
            fif.mem_ack        = (i == delay);
            fif.mem_rdata      = (i == delay) ? data : $urandom;
            fif.redirect_valid = (i == req_redir_at);
            fif.redirect_pc    = req_pc;
            if (i == req_redir_at) begin
                pend    = 1'b1;
                pend_pc = req_pc;
            end
            tick;
            if (i < delay) begin
                check("wait_mem_req", 32'(fif.mem_req), 32'd1);
                check("wait_mem_addr", fif.mem_addr, a);
                check("wait_completed", 32'(fif.completed), 32'd0);
            end
        end
        fif.mem_ack        = 1'b0;
        fif.enabled        = 1'b0;
        fif.redirect_valid = 1'b0;
        check("done_completed", 32'(fif.completed), 32'd1);
        check("done_pc_out", fif.pc_out, a);
        check("done_instr", fif.instr_raw, data);
        check("done_fault", 32'(fif.fault), 32'd0);
        check("done_cause", 32'(fif.fault_cause), 32'd0);
        check("done_mem_req", 32'(fif.mem_req), 32'd0);
        m_pc = pend ? pend_pc : a + 32'd4;
        tick;
        check("idle_completed", 32'(fif.completed), 32'd0);
        check("idle_busy", 32'(fif.busy), 32'd0);
        check("idle_instr_hold", fif.instr_raw, data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        logic [31:0] rp;
        int          d;
        int          ra;

        fif.enabled        = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = '0;
        fif.mem_ack        = 1'b0;
        fif.mem_rdata      = '0;
        rstn = 1'b0;
        tick;
        tick;
        check("rst_mem_req", 32'(fif.mem_req), 32'd0);
        check("rst_mem_addr", fif.mem_addr, 32'd0);
        check("rst_completed", 32'(fif.completed), 32'd0);
        check("rst_pc_out", fif.pc_out, 32'd0);
        check("rst_instr", fif.instr_raw, 32'd0);
        check("rst_fault", 32'(fif.fault), 32'd0);
        check("rst_cause", 32'(fif.fault_cause), 32'd0);
        check("rst_busy", 32'(fif.busy), 32'd0);
        rstn = 1'b1;
        m_pc = RST_PC;

        // Zero-wait fetch, then delays 3 and 7 with a redirect during the fetch at 0x8
        fetch(1'b0, 32'h0, 0, -1, 32'h0, 32'h002181B3, 1'b0);
        fetch(1'b0, 32'h0, 3, -1, 32'h0, 32'hA5A5_0001, 1'b1);
        fetch(1'b0, 32'h0, 7, 2, 32'h0000_0100, 32'hA5A5_0002, 1'b1);
        check("redirect_target", m_pc, 32'h0000_0100);
        fetch(1'b0, 32'h0, 1, -1, 32'h0, 32'hA5A5_0003, 1'b0);

        // Misaligned redirect with enable, retry faults at the same address
        fetch(1'b1, 32'h0000_0102, 0, -1, 32'h0, 32'h0, 1'b0);
        fetch(1'b0, 32'h0, 0, -1, 32'h0, 32'h0, 1'b0);
        fetch(1'b1, 32'h0000_0200, 2, -1, 32'h0, 32'h1234_5678, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        fif.enabled = 1'b1;
        tick;
        fif.enabled = 1'b0;
        a = m_pc;
        check("to_mem_req", 32'(fif.mem_req), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick;
            check("to_wait_req", 32'(fif.mem_req), 32'd1);
            check("to_wait_completed", 32'(fif.completed), 32'd0);
        end
        tick;
        check("to_completed", 32'(fif.completed), 32'd1);
        check("to_fault", 32'(fif.fault), 32'd1);
        check("to_cause", 32'(fif.fault_cause), 32'd2);
        check("to_instr", fif.instr_raw, NOP);
        check("to_pc_out", fif.pc_out, a);
        check("to_mem_req_drop", 32'(fif.mem_req), 32'd0);
        tick;
        check("to_busy_drop", 32'(fif.busy), 32'd0);
        // Ack in the 16th REQ cycle wins over the timeout
        fetch(1'b0, 32'h0, 15, -1, 32'h0, 32'hCAFE_0016, 1'b0);
`else
        fetch(1'b0, 32'h0, 20, -1, 32'h0, 32'hCAFE_0020, 1'b0);
`endif

        // PC wraps from the top of the address space
        fetch(1'b1, 32'hFFFF_FFFC, 1, -1, 32'h0, 32'h0BAD_F00D, 1'b0);
        check("wrap_model", m_pc, 32'h0);
        fetch(1'b0, 32'h0, 0, -1, 32'h0, 32'h1111_2222, 1'b0);

        // Reset in REQ aborts the fetch; a stray ack afterwards is ignored
        fif.enabled = 1'b1;
        tick;
        fif.enabled = 1'b0;
        check("abort_mem_req", 32'(fif.mem_req), 32'd1);
        tick;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        check("abort_mem_req_low", 32'(fif.mem_req), 32'd0);
        check("abort_busy", 32'(fif.busy), 32'd0);
        check("abort_pc_out", fif.pc_out, 32'd0);
        check("abort_instr", fif.instr_raw, 32'd0);
        fif.mem_ack   = 1'b1;
        fif.mem_rdata = 32'hDEAD_BEEF;
        tick;
        fif.mem_ack = 1'b0;
        check("stray_completed", 32'(fif.completed), 32'd0);
        check("stray_busy", 32'(fif.busy), 32'd0);
        tick;
        check("stray_completed2", 32'(fif.completed), 32'd0);
        m_pc = RST_PC;
        fetch(1'b0, 32'h0, 2, -1, 32'h0, 32'h3333_4444, 1'b0);

        // Randomized fetches with redirects in IDLE and during the wait
        for (int n = 0; n < 30; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            rp = $urandom;
            rp[1:0] = 2'b00;
            d  = int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7));
            fetch(($urandom_range(0, 3) == 0), r, d, ra, rp, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the multi-cycle core; sits directly upstream of decode.
- Owns the program counter and issues one instruction-memory read per `enabled` pulse.
- Presents `pc_out` / `instr_raw` to decode with a one-cycle `completed` pulse, using the same enabled/completed protocol as decode and execute.
- Accepts PC redirects from execute/write for branches and jumps, and reports misaligned-address and (optional) memory-timeout faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven on `instr_raw` when a fault occurs (ADDI x0,x0,0).
- TIMEOUT_CYCLES, 16, maximum number of REQ-state cycles without `mem_ack`; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- enabled  in  1  start-fetch pulse from core control; sampled only in IDLE.
- redirect_valid  in  1  load a new PC from redirect_pc.
- redirect_pc  in  32  branch/jump target, byte address.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  byte address of the request.
- mem_ack  in  1  memory has returned data this cycle.
- mem_rdata  in  32  instruction word; valid when mem_ack=1.
- completed  out  1  one-cycle pulse: pc_out, instr_raw and fault are valid.
- pc_out  out  32  address of the fetched instruction.
- instr_raw  out  32  fetched instruction word, to decode.
- fault  out  1  the last fetch faulted.
- fault_cause  out  2  01 = misaligned, 10 = timeout, 00 = none.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rstn=0 at a rising edge) puts the block in this state:
  - state=IDLE, pc=RESET_PC.
  - mem_req=0, mem_addr=0, completed=0.
  - pc_out=0, instr_raw=0, fault=0, fault_cause=00, busy=0.
  - pending-redirect flag cleared; timeout counter cleared.
  - Reset mid-fetch aborts the fetch. A late mem_ack after reset is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - Fetch address A = redirect_pc if redirect_valid=1, else pc. If redirect_valid=1, pc <= redirect_pc (also when enabled=0).
  - enabled=1 and A[1:0]!=0: no memory request. Go to DONE with fault=1, fault_cause=01, instr_raw=NOP_INSTR, pc_out=A.
  - enabled=1 and A aligned: mem_req <= 1, mem_addr <= A, go to REQ.
  - enabled=0: stay in IDLE.
- REQ:
  - mem_req and mem_addr are held stable until a cycle with mem_ack=1.
  - On mem_ack: mem_req <= 0, instr_raw <= mem_rdata, pc_out <= mem_addr, fault <= 0, fault_cause <= 00, go to DONE.
  - Ack is allowed in the first REQ cycle (zero-wait memory).
- DONE: completed=1 for exactly one cycle, then return to IDLE.
- PC update at DONE:
  - Pending redirect: pc <= latched redirect_pc.
  - Else if fault: pc unchanged, so a retry refetches the same address.
  - Else: pc <= pc_out + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- redirect_valid while in REQ or DONE: latch redirect_pc into the pending-redirect flag. The last one wins. The in-flight fetch still completes at its original address.
- enabled outside IDLE is ignored, with no queuing.
- pc_out, instr_raw, fault and fault_cause hold their values until the next DONE.
- Latency: enabled in cycle 0 -> mem_req high in cycle 1. Ack in cycle 1+k -> completed in cycle 2+k. Minimum is 2 cycles. A misaligned fault completes in cycle 1.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter runs in REQ and is cleared on entering REQ.
  - If TIMEOUT_CYCLES REQ cycles elapse without mem_ack: mem_req <= 0, go to DONE with fault=1, fault_cause=10, instr_raw=NOP_INSTR, pc_out=mem_addr.
  - An ack arriving in the same cycle as the timeout wins: a normal completion, no fault.
- Not defined: no counter logic; REQ waits indefinitely, and fault_cause=10 never occurs.

Test Plan:
- Reset, enabled pulse, memory acks in the first REQ cycle with 32'h002181B3 -> completed in cycle 2, pc_out=0, instr_raw=32'h002181B3, fault=0, next pc=4.
- Three back-to-back fetches with acks delayed 0/3/7 cycles -> pc_out=0,4,8; completed is one cycle each; mem_addr is stable throughout each wait.
- redirect_valid with redirect_pc=32'h100 during REQ of the fetch at 0x8 -> that fetch completes with pc_out=8; the next fetch goes to mem_addr=32'h100.
- Redirect to 32'h102 together with enabled in IDLE -> no mem_req; completed next cycle with fault=1, cause=01, instr_raw=32'h00000013; the retry refetches 0x102.
- With FETCH_TIMEOUT_EN and no ack -> completed after 16 REQ cycles with fault=1, cause=10, pc unchanged. Repeat with the ack arriving exactly in the 16th cycle -> normal completion.
- rstn low during REQ, then a stray mem_ack -> IDLE, mem_req=0, pc=RESET_PC, no completed pulse. pc=32'hFFFFFFFC fetch -> next pc=0.
